// File: rtl/jk_ff_driver_if.sv
// Target handshake bundle for jk_ff_driver.
//   i_TARGET        desired Q value offered by the producer
//   i_TARGET_VALID  target offered
//   o_TARGET_READY  target FIFO not full; transfer on valid & ready at a rising edge
// master: producer side, slave: jk_ff_driver side.
interface jk_ff_driver_if;
  logic i_TARGET;
  logic i_TARGET_VALID;
  logic o_TARGET_READY;

  modport master (output i_TARGET, output i_TARGET_VALID, input  o_TARGET_READY);
  modport slave  (input  i_TARGET, input  i_TARGET_VALID, output o_TARGET_READY);
endinterface

// File: rtl/jk_ff_driver.sv
// Sequencer driving an external async-preset/reset JK flip-flop towards a
// stream of target Q values, and checking the flip-flop's fed-back Q.
//   i_CLOCK_POS / i_RESET_NEG   rising-edge clock, async active-low reset
//   tgt (slave)                 target valid/ready handshake into a DEPTH FIFO
//   i_INIT_REQ / i_INIT_VALUE   one-cycle async init of the flip-flop (1=preset)
//   i_SIGNAL_Q                  Q fed back from the driven flip-flop
//   o_SIGNAL_J / o_SIGNAL_K     registered excitation
//   o_FF_PRESET_NEG/RESET_NEG   registered active-low init pulses
//   o_SYNCED                    checker armed (any init done)
//   o_ERROR / o_ERR_COUNT       sticky mismatch flag / saturating mismatch count
//   o_BUSY                      FIFO non-empty or INIT in progress
module jk_ff_driver #(
  parameter int unsigned DEPTH       = 4,
  parameter bit          TOGGLE_MODE = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             i_CLOCK_POS,
  input  logic             i_RESET_NEG,
  jk_ff_driver_if.slave    tgt,
  input  logic             i_INIT_REQ,
  input  logic             i_INIT_VALUE,
  input  logic             i_SIGNAL_Q,
  output logic             o_SIGNAL_J,
  output logic             o_SIGNAL_K,
  output logic             o_FF_PRESET_NEG,
  output logic             o_FF_RESET_NEG,
  output logic             o_SYNCED,
  output logic             o_ERROR,
  output logic [CNT_W-1:0] o_ERR_COUNT,
  output logic             o_BUSY
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_INIT} state_t;

  // state_d names the action taken at the coming edge; state_q then holds
  // that phase for the following cycle (so S_INIT lasts exactly one cycle).
  state_t state_q, state_d;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             q_model_q, q_model_d;
  logic             j_q, j_d, k_q, k_d;
  logic             preset_n_q, preset_n_d, reset_n_q, reset_n_d;
  logic             synced_q, synced_d;
  logic             s1_vld_q, s1_vld_d, s1_q, s1_d;
  logic             s2_vld_q, s2_vld_d, s2_q, s2_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic full, empty, push, pop, head, mismatch;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Init wins over pop; otherwise pop whenever the FIFO held an entry before
  // this edge (no bypass of a same-cycle push).
  always_comb begin
    state_d = S_IDLE;
    if (i_INIT_REQ)  state_d = S_INIT;
    else if (!empty) state_d = S_DRIVE;
  end

  always_comb begin
    push       = tgt.i_TARGET_VALID && !full;
    pop        = (state_d == S_DRIVE);
    head       = mem_q[rd_ptr_q];

    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = tgt.i_TARGET;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);

    j_d        = 1'b0;
    k_d        = 1'b0;
    preset_n_d = 1'b1;
    reset_n_d  = 1'b1;
    q_model_d  = q_model_q;
    synced_d   = synced_q;

    case (state_d)
      S_INIT: begin
        preset_n_d = !i_INIT_VALUE;
        reset_n_d  = i_INIT_VALUE;
        q_model_d  = i_INIT_VALUE;
        synced_d   = 1'b1;
      end
      S_DRIVE: begin
        if (head != q_model_q) begin
          if (TOGGLE_MODE) begin
            j_d = 1'b1;
            k_d = 1'b1;
          end else begin
            j_d = head;
            k_d = !head;
          end
        end
        q_model_d = head;
      end
      default: ;
    endcase

    // Two-stage model delay matches excitation -> FF sample -> compare.
    // An init flushes stage 2 so the pre-init value is never compared.
    s1_vld_d  = 1'b1;
    s1_d      = q_model_d;
    s2_vld_d  = s1_vld_q && (state_d != S_INIT);
    s2_d      = s1_q;

    mismatch  = s2_vld_q && synced_q && (i_SIGNAL_Q != s2_q);
    error_d   = error_q || mismatch;
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      q_model_q  <= 1'b0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      preset_n_q <= 1'b1;
      reset_n_q  <= 1'b1;
      synced_q   <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_q       <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_q       <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      q_model_q  <= q_model_d;
      j_q        <= j_d;
      k_q        <= k_d;
      preset_n_q <= preset_n_d;
      reset_n_q  <= reset_n_d;
      synced_q   <= synced_d;
      s1_vld_q   <= s1_vld_d;
      s1_q       <= s1_d;
      s2_vld_q   <= s2_vld_d;
      s2_q       <= s2_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign tgt.o_TARGET_READY = !full;
  assign o_SIGNAL_J         = j_q;
  assign o_SIGNAL_K         = k_q;
  assign o_FF_PRESET_NEG    = preset_n_q;
  assign o_FF_RESET_NEG     = reset_n_q;
  assign o_SYNCED           = synced_q;
  assign o_ERROR            = error_q;
  assign o_ERR_COUNT        = err_cnt_q;
  assign o_BUSY             = !empty || (state_q == S_INIT);

endmodule

// File: tb/tb_jk_ff_driver.sv
// Bench for jk_ff_driver: two instances (index 0: set/reset mode, index 1:
// toggle mode) share all stimulus, each drives its own behavioural JK FF.
module tb_jk_ff_driver;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_req = 1'b0, init_val = 1'b0;
  logic target = 1'b0, tvalid = 1'b0;
  logic stuck_en = 1'b0, stuck_val = 1'b0;

  logic [1:0] j, k, pre_n, clr_n, synced, err, busy, q_fb;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic ff0 = 1'b0, ff1 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_ff_driver_if bus0 ();
  jk_ff_driver_if bus1 ();
  assign bus0.i_TARGET = target;
  assign bus0.i_TARGET_VALID = tvalid;
  assign bus1.i_TARGET = target;
  assign bus1.i_TARGET_VALID = tvalid;

  jk_ff_driver #(.DEPTH(DEPTH), .TOGGLE_MODE(1'b0), .CNT_W(CNT_W)) dut0 (
    .i_CLOCK_POS(clk), .i_RESET_NEG(rst_n), .tgt(bus0),
    .i_INIT_REQ(init_req), .i_INIT_VALUE(init_val), .i_SIGNAL_Q(q_fb[0]),
    .o_SIGNAL_J(j[0]), .o_SIGNAL_K(k[0]),
    .o_FF_PRESET_NEG(pre_n[0]), .o_FF_RESET_NEG(clr_n[0]),
    .o_SYNCED(synced[0]), .o_ERROR(err[0]), .o_ERR_COUNT(cnt0), .o_BUSY(busy[0]));

  jk_ff_driver #(.DEPTH(DEPTH), .TOGGLE_MODE(1'b1), .CNT_W(CNT_W)) dut1 (
    .i_CLOCK_POS(clk), .i_RESET_NEG(rst_n), .tgt(bus1),
    .i_INIT_REQ(init_req), .i_INIT_VALUE(init_val), .i_SIGNAL_Q(q_fb[1]),
    .o_SIGNAL_J(j[1]), .o_SIGNAL_K(k[1]),
    .o_FF_PRESET_NEG(pre_n[1]), .o_FF_RESET_NEG(clr_n[1]),
    .o_SYNCED(synced[1]), .o_ERROR(err[1]), .o_ERR_COUNT(cnt1), .o_BUSY(busy[1]));

  // Driven flip-flops: ideal JK with async preset/clear.
  always @(posedge clk or negedge pre_n[0] or negedge clr_n[0]) begin
    if (!pre_n[0])      ff0 <= 1'b1;
    else if (!clr_n[0]) ff0 <= 1'b0;
    else case ({j[0], k[0]})
      2'b10: ff0 <= 1'b1;
      2'b01: ff0 <= 1'b0;
      2'b11: ff0 <= ~ff0;
      default: ;
    endcase
  end
  always @(posedge clk or negedge pre_n[1] or negedge clr_n[1]) begin
    if (!pre_n[1])      ff1 <= 1'b1;
    else if (!clr_n[1]) ff1 <= 1'b0;
    else case ({j[1], k[1]})
      2'b10: ff1 <= 1'b1;
      2'b01: ff1 <= 1'b0;
      2'b11: ff1 <= ~ff1;
      default: ;
    endcase
  end
  assign q_fb[0] = stuck_en ? stuck_val : ff0;
  assign q_fb[1] = stuck_en ? stuck_val : ff1;

  // Reference model: queue FIFO, current model value, short history of the
  // model value per edge for the 2-edge check latency.
  typedef struct {bit val; bit init;} hist_t;
  bit      fifo[$];
  hist_t   hist[$];
  bit      mq, m_pre, m_clr, m_synced, m_init_last;
  bit [1:0] m_j, m_k, m_err;
  int      m_cnt[2];

  task automatic model_reset();
    fifo.delete();
    hist.delete();
    mq = 0; m_pre = 1; m_clr = 1; m_synced = 0; m_init_last = 0;
    m_j = '0; m_k = '0; m_err = '0; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // Called with the inputs that will be present at the next rising edge.
  task automatic model_edge();
    bit do_init, do_pop, do_push, t;
    do_init = init_req;
    do_push = tvalid && (fifo.size() < DEPTH);
    do_pop  = !init_req && (fifo.size() != 0);
    for (int m = 0; m < 2; m++)
      if (m_synced && hist.size() >= 2 && !hist[hist.size()-1].init &&
          q_fb[m] != hist[hist.size()-2].val) begin
        m_err[m] = 1;
        if (m_cnt[m] < CNT_MAX) m_cnt[m]++;
      end
    m_pre = 1; m_clr = 1; m_j = '0; m_k = '0;
    if (do_init) begin
      if (init_val) m_pre = 0; else m_clr = 0;
      mq = init_val;
      m_synced = 1;
    end else if (do_pop) begin
      t = fifo.pop_front();
      if (t != mq) begin
        m_j[1] = 1; m_k[1] = 1;
        m_j[0] = t; m_k[0] = !t;
      end
      mq = t;
    end
    if (do_push) fifo.push_back(target);
    m_init_last = do_init;
    hist.push_back('{val: mq, init: do_init});
    if (hist.size() > 2) void'(hist.pop_front());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [CNT_W-1:0] c;
    logic rdy;
    for (int m = 0; m < 2; m++) begin
      c   = (m == 0) ? cnt0 : cnt1;
      rdy = (m == 0) ? bus0.o_TARGET_READY : bus1.o_TARGET_READY;
      chk($sformatf("%s.J%0d", tag, m),     {31'd0, j[m]},      {31'd0, m_j[m]});
      chk($sformatf("%s.K%0d", tag, m),     {31'd0, k[m]},      {31'd0, m_k[m]});
      chk($sformatf("%s.PRE%0d", tag, m),   {31'd0, pre_n[m]},  {31'd0, m_pre});
      chk($sformatf("%s.CLR%0d", tag, m),   {31'd0, clr_n[m]},  {31'd0, m_clr});
      chk($sformatf("%s.SYNC%0d", tag, m),  {31'd0, synced[m]}, {31'd0, m_synced});
      chk($sformatf("%s.ERR%0d", tag, m),   {31'd0, err[m]},    {31'd0, m_err[m]});
      chk($sformatf("%s.CNT%0d", tag, m),   32'(c),             32'(m_cnt[m]));
      chk($sformatf("%s.BUSY%0d", tag, m),  {31'd0, busy[m]},
          {31'd0, (fifo.size() != 0) || m_init_last});
      chk($sformatf("%s.READY%0d", tag, m), {31'd0, rdy},       {31'd0, fifo.size() < DEPTH});
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  logic [1:0] exp_tog [4] = '{2'b11, 2'b00, 2'b11, 2'b11};
  logic [1:0] exp_sr  [4] = '{2'b10, 2'b00, 2'b01, 2'b10};
  logic       seq_a   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Init 0, then push 1,1,0,1 back to back
    init_req = 1; init_val = 0;
    tick("a_init");
    init_req = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin target = seq_a[i]; tvalid = 1; end
      else tvalid = 0;
      tick("a_seq");
      if (i >= 1) begin
        chk("a_jk_toggle", {30'd0, j[1], k[1]}, {30'd0, exp_tog[i-1]});
        chk("a_jk_setrst", {30'd0, j[0], k[0]}, {30'd0, exp_sr[i-1]});
      end
    end
    for (int i = 0; i < 3; i++) tick("a_tail");
    chk("a_no_error", {31'd0, err[1]}, 32'd0);

    // Fill with init held: 4 accepted, 5th refused
    init_req = 1; init_val = 1'($urandom_range(0, 1));
    for (int i = 0; i < DEPTH + 1; i++) begin
      target = 1'($urandom_range(0, 1)); tvalid = 1;
      tick("fill");
      if (i == DEPTH - 1) chk("fill_ready_low", {31'd0, bus0.o_TARGET_READY}, 32'd0);
    end
    init_req = 0; tvalid = 0;
    tick("drain_first");
    chk("ready_after_pop", {31'd0, bus1.o_TARGET_READY}, 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) tick("drain");

    // Init while FIFO holds entries; pops resume from the init value
    init_req = 1; init_val = 0;
    target = 1; tvalid = 1; tick("ie_push1");
    target = 0; tick("ie_push0");
    tvalid = 0; init_val = 1; tick("ie_init");
    chk("ie_preset_pulse", {31'd0, pre_n[1]}, 32'd0);
    chk("ie_reset_idle",   {31'd0, clr_n[1]}, 32'd1);
    init_req = 0;
    tick("ie_pop1");
    chk("ie_jk_same",  {30'd0, j[1], k[1]}, 32'd0);
    tick("ie_pop0");
    chk("ie_jk_tog",   {30'd0, j[1], k[1]}, 32'd3);
    chk("ie_jk_rst",   {30'd0, j[0], k[0]}, 32'd1);

    // Randomised traffic with occasional inits, ideal flip-flops
    for (int i = 0; i < 300; i++) begin
      target   = 1'($urandom_range(0, 1));
      tvalid   = ($urandom_range(0, 9) < 7);
      init_req = ($urandom_range(0, 19) == 0);
      init_val = 1'($urandom_range(0, 1));
      tick("rand");
    end
    init_req = 0; tvalid = 0;
    for (int i = 0; i < DEPTH + 2; i++) tick("rand_drain");

    // Feedback stuck at 0: error two edges after the pop, count saturates
    init_req = 1; init_val = 0; tick("st_init");
    init_req = 0; stuck_en = 1; stuck_val = 0;
    target = 1; tvalid = 1; tick("st_push");
    tvalid = 0; tick("st_pop");
    tick("st_e1");
    chk("st_err_not_yet", {31'd0, err[1]}, 32'd0);
    tick("st_e2");
    chk("st_err_set", {31'd0, err[1]}, 32'd1);
    chk("st_cnt_one", 32'(cnt1), 32'd1);
    for (int i = 0; i < CNT_MAX + 5; i++) tick("st_run");
    chk("st_cnt_sat", 32'(cnt0), 32'(CNT_MAX));
    stuck_en = 0;

    // Asynchronous reset mid-stream
    init_req = 1; init_val = 1;
    for (int i = 0; i < 3; i++) begin
      target = 1'($urandom_range(0, 1)); tvalid = 1; tick("mr_fill");
    end
    init_req = 0; tick("mr_pop");
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all("mr_async");
    tvalid = 0;
    @(posedge clk); #1;
    check_all("mr_hold");
    rst_n = 1;
    for (int i = 0; i < 3; i++) tick("mr_after");

    // Short randomised run after reset
    for (int i = 0; i < 100; i++) begin
      target   = 1'($urandom_range(0, 1));
      tvalid   = ($urandom_range(0, 1) == 1);
      init_req = ($urandom_range(0, 9) == 0);
      init_val = 1'($urandom_range(0, 1));
      tick("rand2");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
